// File: rtl/spart_tx.sv
// SPART transmitter: one-entry holding register feeding a shift register that
// serializes 8N1 frames on txd, with bit timing from the shared baud divisor.
module spart_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  divisor_buffer,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tbr,
    output logic              tx_busy,
    output logic              txd
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [0:0] {StIdle, StTx} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]    baud_q, baud_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                txd_q, txd_d;
    logic                load_frame;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '1;
            bit_cnt_q   <= '0;
            baud_q      <= '0;
            div_q       <= '0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_q      <= baud_d;
            div_q       <= div_d;
            txd_q       <= txd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_d      = baud_q;
        div_d       = div_q;
        txd_d       = txd_q;
        load_frame  = 1'b0;

        // A write while the holding register is occupied is simply dropped.
        if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (hold_full_q) begin
                    load_frame = 1'b1;
                end
            end
            StTx: begin
                if (baud_q == '0) begin
                    baud_d    = div_q;
                    shift_d   = {1'b1, shift_q[FRAME_W-1:1]};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    txd_d     = shift_q[1];
                    // End of stop bit: chain straight into the next frame if one waits.
                    if (bit_cnt_q == CNT_W'(1)) begin
                        if (hold_full_q) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = StIdle;
                            txd_d   = 1'b1;
                        end
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase

        if (load_frame) begin
            state_d     = StTx;
            shift_d     = {1'b1, hold_q, 1'b0};
            div_d       = divisor_buffer;
            baud_d      = divisor_buffer;
            bit_cnt_d   = CNT_W'(FRAME_W);
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
        end
    end

    assign tbr     = !hold_full_q;
    assign tx_busy = (state_q == StTx);
    assign txd     = txd_q;

endmodule
